// File: rtl/hex_watch.sv
// hex_watch -- seven-segment display watcher.
//
// Classifies an observed active-low seven-segment pattern as BLANK, STEADY,
// BLINK or ERROR. It measures the period between blink edges (digit<->blank
// changes) and flags undecodable patterns with a sticky error bit.
//
// Parameters
//   WIDTH    width of the run-length counter and of the period output
//   TIMEOUT  unchanged cycles after which the display counts as settled
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high reset
//   hex[6:0]    observed pattern, active-low segments, 7'b1111111 = blank
//   digit[1:0]  last decoded digit
//   state[1:0]  00 BLANK, 01 STEADY, 10 BLINK, 11 ERROR
//   period      cycles between the last two blink edges (saturating)
//   blink_edge  one-cycle pulse on each blink edge (edge is a reserved word)
//   err         sticky flag for any undecodable pattern, cleared by reset
//   jitter      one-cycle pulse on a blink-period mismatch
//
// Optional feature: define HEX_WATCH_PERIOD_CHECK_EN to compare consecutive
// blink periods within one BLINK episode. When it is undefined, jitter is
// constant 0 and the period-compare logic is not built.

module hex_watch #(
   parameter int              WIDTH   = 14,
   parameter logic [WIDTH-1:0] TIMEOUT = 14'd10000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       hex,
   output logic [1:0]       digit,
   output logic [1:0]       state,
   output logic [WIDTH-1:0] period,
   output logic             blink_edge,
   output logic             err,
   output logic             jitter
);

   localparam logic [1:0] ST_BLANK  = 2'd0;
   localparam logic [1:0] ST_STEADY = 2'd1;
   localparam logic [1:0] ST_BLINK  = 2'd2;
   localparam logic [1:0] ST_ERROR  = 2'd3;

   localparam logic [1:0] CLS_DIGIT = 2'd0;
   localparam logic [1:0] CLS_BLANK = 2'd1;
   localparam logic [1:0] CLS_BAD   = 2'd2;

   localparam logic [6:0] PAT_ZERO  = 7'b1000000;

   localparam logic [WIDTH-1:0] RUN_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   // Pattern class: decodable digit, blank, or undecodable.
   function automatic logic [1:0] seg_class(input logic [6:0] p);
      case (p)
         7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000: seg_class = CLS_DIGIT;
         7'b1111111:                                      seg_class = CLS_BLANK;
         default:                                         seg_class = CLS_BAD;
      endcase
   endfunction

   // Digit value of a decodable pattern; non-digits map to 0 and are never used.
   function automatic logic [1:0] seg_value(input logic [6:0] p);
      case (p)
         7'b1111001: seg_value = 2'd1;
         7'b0100100: seg_value = 2'd2;
         7'b0110000: seg_value = 2'd3;
         default:    seg_value = 2'd0;
      endcase
   endfunction

   logic [6:0]       hex_q_r;
   logic [WIDTH-1:0] run_r,    run_s;
   logic [1:0]       digit_r,  digit_s;
   logic [1:0]       state_r,  state_s;
   logic [WIDTH-1:0] period_r, period_s;
   logic             edge_r,   edge_s;
   logic             err_r,    err_s;

   logic             change_s;
   logic [1:0]       new_cls_s, old_cls_s;
   logic [WIDTH-1:0] run_inc_s;

   // Change detection, pattern classes and saturating run+1.
   always_comb begin
      change_s  = (hex != hex_q_r);
      new_cls_s = seg_class(hex);
      old_cls_s = seg_class(hex_q_r);
      if (run_r == RUN_MAX) begin
         run_inc_s = RUN_MAX;
      end else begin
         run_inc_s = run_r + ONE;
      end
   end

   // Next-state logic: a change always takes precedence over the settle timeout.
   always_comb begin
      run_s    = run_r;
      digit_s  = digit_r;
      state_s  = state_r;
      period_s = period_r;
      edge_s   = 1'b0;
      err_s    = err_r;
      if (change_s) begin
         run_s = '0;
         if (new_cls_s == CLS_BAD) begin
            state_s = ST_ERROR;
            err_s   = 1'b1;
         end else if (old_cls_s == CLS_BAD) begin
            // Recovering from an invalid pattern is not a blink edge.
            if (new_cls_s == CLS_DIGIT) begin
               state_s = ST_STEADY;
               digit_s = seg_value(hex);
            end else begin
               state_s = ST_BLANK;
            end
         end else if (old_cls_s != new_cls_s) begin
            // digit <-> blank: blink edge
            edge_s   = 1'b1;
            period_s = run_inc_s;
            state_s  = ST_BLINK;
            if (new_cls_s == CLS_DIGIT) begin
               digit_s = seg_value(hex);
            end else begin
               digit_s = digit_r;
            end
         end else begin
            // digit to a different digit
            state_s = ST_STEADY;
            digit_s = seg_value(hex);
         end
      end else begin
         run_s = run_inc_s;
         if (run_inc_s == TIMEOUT) begin
            case (old_cls_s)
               CLS_DIGIT: state_s = ST_STEADY;
               CLS_BLANK: state_s = ST_BLANK;
               default:   state_s = ST_ERROR;
            endcase
         end else begin
            state_s = state_r;
         end
      end
   end

   // State register; reset restores the power-on view of a displayed 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         hex_q_r  <= PAT_ZERO;
         run_r    <= '0;
         digit_r  <= 2'd0;
         state_r  <= ST_STEADY;
         period_r <= '0;
         edge_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         hex_q_r  <= hex;
         run_r    <= run_s;
         digit_r  <= digit_s;
         state_r  <= state_s;
         period_r <= period_s;
         edge_r   <= edge_s;
         err_r    <= err_s;
      end
   end

`ifdef HEX_WATCH_PERIOD_CHECK_EN
   logic [WIDTH-1:0] prev_period_r, prev_period_s;
   logic             prev_valid_r,  prev_valid_s;
   logic             jitter_r,      jitter_s;
   logic [WIDTH-1:0] diff_s;

   // Period comparison: the edge that enters BLINK only arms the history; the
   // first in-episode period is stored, later ones are compared (tolerance 1).
   always_comb begin
      prev_period_s = prev_period_r;
      prev_valid_s  = prev_valid_r;
      jitter_s      = 1'b0;
      if (run_inc_s >= prev_period_r) begin
         diff_s = run_inc_s - prev_period_r;
      end else begin
         diff_s = prev_period_r - run_inc_s;
      end
      if (edge_s) begin
         if (state_r != ST_BLINK) begin
            prev_period_s = '0;
            prev_valid_s  = 1'b0;
         end else begin
            if (prev_valid_r && (diff_s > ONE)) begin
               jitter_s = 1'b1;
            end else begin
               jitter_s = 1'b0;
            end
            prev_period_s = run_inc_s;
            prev_valid_s  = 1'b1;
         end
      end else begin
         prev_valid_s = prev_valid_r;
      end
   end

   // Period-history register.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_period_r <= '0;
         prev_valid_r  <= 1'b0;
         jitter_r      <= 1'b0;
      end else begin
         prev_period_r <= prev_period_s;
         prev_valid_r  <= prev_valid_s;
         jitter_r      <= jitter_s;
      end
   end
`endif

   // Output drive straight from registers.
   always_comb begin
      digit      = digit_r;
      state      = state_r;
      period     = period_r;
      blink_edge = edge_r;
      err        = err_r;
`ifdef HEX_WATCH_PERIOD_CHECK_EN
      jitter     = jitter_r;
`else
      jitter     = 1'b0;
`endif
   end

endmodule

// File: tb/tb_hex_watch.sv
module tb_hex_watch;

   localparam logic [6:0] ZERO  = 7'b1000000;
   localparam logic [6:0] ONE_P = 7'b1111001;
   localparam logic [6:0] TWO   = 7'b0100100;
   localparam logic [6:0] THREE = 7'b0110000;
   localparam logic [6:0] BLK   = 7'b1111111;
   localparam logic [6:0] BAD0  = 7'b0000000;
   localparam logic [6:0] BAD1  = 7'b0000001;

   localparam logic [1:0] SB = 2'd0;  // BLANK
   localparam logic [1:0] SS = 2'd1;  // STEADY
   localparam logic [1:0] SL = 2'd2;  // BLINK
   localparam logic [1:0] SE = 2'd3;  // ERROR

`ifdef HEX_WATCH_PERIOD_CHECK_EN
   localparam int JIT_EXP = 1;
`else
   localparam int JIT_EXP = 0;
`endif

   logic       clk;
   logic       reset;
   logic [6:0] hex;
   logic [1:0] digit;
   logic [1:0] state;
   logic [5:0] period;
   logic       blink_edge;
   logic       err;
   logic       jitter;

   int n_vec;
   int n_cmp;
   int n_bad;

   hex_watch #(.WIDTH(6), .TIMEOUT(6'd20)) dut (
      .clk        (clk),
      .reset      (reset),
      .hex        (hex),
      .digit      (digit),
      .state      (state),
      .period     (period),
      .blink_edge (blink_edge),
      .err        (err),
      .jitter     (jitter)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [6:0] hx;
      int         n;      // cycles to hold this input
      logic [1:0] dg;     // expected after the last cycle
      logic [1:0] st;
      logic [5:0] per;
      int         edges;  // edge pulses seen during the n cycles
      logic       er;
      int         jits;   // jitter pulses seen during the n cycles
   } vec_t;

   vec_t vecs[27];

   task automatic chk(input string name, input int idx, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, output int ec, output int jc);
      reset = v.rst;
      hex   = v.hx;
      ec    = 0;
      jc    = 0;
      for (int k = 0; k < v.n; k++) begin
         @(posedge clk);
         #1;
         ec += int'(blink_edge);
         jc += int'(jitter);
      end
   endtask

   initial begin
      int ec;
      int jc;
      n_vec = 0;
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      hex   = ZERO;

      //           rst   hex    n   dig   st  per edg err jit
      vecs[0]  = '{1'b1, ZERO,  1,  2'd0, SS, 6'd0,  0, 1'b0, 0};
      vecs[1]  = '{1'b0, ZERO,  30, 2'd0, SS, 6'd0,  0, 1'b0, 0};
      vecs[2]  = '{1'b0, TWO,   8,  2'd2, SS, 6'd0,  0, 1'b0, 0};
      vecs[3]  = '{1'b0, BLK,   8,  2'd2, SL, 6'd8,  1, 1'b0, 0};
      vecs[4]  = '{1'b0, TWO,   8,  2'd2, SL, 6'd8,  1, 1'b0, 0};
      vecs[5]  = '{1'b0, BLK,   1,  2'd2, SL, 6'd8,  1, 1'b0, 0};
      vecs[6]  = '{1'b0, BLK,   19, 2'd2, SL, 6'd8,  0, 1'b0, 0};
      vecs[7]  = '{1'b0, BLK,   1,  2'd2, SB, 6'd8,  0, 1'b0, 0};
      vecs[8]  = '{1'b0, BAD0,  1,  2'd2, SE, 6'd8,  0, 1'b1, 0};
      vecs[9]  = '{1'b0, ONE_P, 1,  2'd1, SS, 6'd8,  0, 1'b1, 0};
      vecs[10] = '{1'b0, ONE_P, 69, 2'd1, SS, 6'd8,  0, 1'b1, 0};
      vecs[11] = '{1'b0, BLK,   1,  2'd1, SL, 6'd63, 1, 1'b1, 0};
      vecs[12] = '{1'b0, ONE_P, 1,  2'd1, SL, 6'd1,  1, 1'b1, 0};
      vecs[13] = '{1'b1, BLK,   1,  2'd0, SS, 6'd0,  0, 1'b0, 0};
      vecs[14] = '{1'b0, BLK,   1,  2'd0, SL, 6'd1,  1, 1'b0, 0};
      vecs[15] = '{1'b0, THREE, 1,  2'd3, SL, 6'd1,  1, 1'b0, 0};
      vecs[16] = '{1'b0, ZERO,  1,  2'd0, SS, 6'd1,  0, 1'b0, 0};
      vecs[17] = '{1'b0, THREE, 5,  2'd3, SS, 6'd1,  0, 1'b0, 0};
      vecs[18] = '{1'b0, BLK,   8,  2'd3, SL, 6'd5,  1, 1'b0, 0};
      vecs[19] = '{1'b0, THREE, 8,  2'd3, SL, 6'd8,  1, 1'b0, 0};
      vecs[20] = '{1'b0, BLK,   11, 2'd3, SL, 6'd8,  1, 1'b0, 0};
      vecs[21] = '{1'b0, THREE, 1,  2'd3, SL, 6'd11, 1, 1'b0, JIT_EXP};
      vecs[22] = '{1'b0, BAD1,  1,  2'd3, SE, 6'd11, 0, 1'b1, 0};
      vecs[23] = '{1'b0, BLK,   1,  2'd3, SB, 6'd11, 0, 1'b1, 0};
      vecs[24] = '{1'b0, TWO,   1,  2'd2, SL, 6'd1,  1, 1'b1, 0};
      vecs[25] = '{1'b0, TWO,   19, 2'd2, SL, 6'd1,  0, 1'b1, 0};
      vecs[26] = '{1'b0, BLK,   1,  2'd2, SL, 6'd20, 1, 1'b1, 0};

      for (int i = 0; i < 27; i++) begin
         apply(vecs[i], ec, jc);
         n_vec++;
         chk("digit",  i, int'(digit),  int'(vecs[i].dg));
         chk("state",  i, int'(state),  int'(vecs[i].st));
         chk("period", i, int'(period), int'(vecs[i].per));
         chk("edges",  i, ec,           vecs[i].edges);
         chk("err",    i, int'(err),    int'(vecs[i].er));
         chk("jitter", i, jc,           vecs[i].jits);
      end

      // Hand sequence: reset clears sticky err, edge pulse is exactly one cycle.
      reset = 1'b1;
      hex   = BAD0;
      @(posedge clk); #1;
      n_vec++;
      chk("rst_err",   100, int'(err),   0);
      chk("rst_state", 100, int'(state), int'(SS));
      reset = 1'b0;
      hex   = BLK;
      @(posedge clk); #1;
      n_vec++;
      chk("edge_on",   101, int'(blink_edge), 1);
      chk("edge_per",  101, int'(period),     1);
      @(posedge clk); #1;
      n_vec++;
      chk("edge_off",  102, int'(blink_edge), 0);
      chk("edge_st",   102, int'(state),      int'(SL));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
